double_dabble_hs: RTL

DOUBLE_DABBLE_HS -- requirements
Module: double_dabble_hs

---
 rtl/double_dabble_hs.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/double_dabble_hs.sv
// -----------------------------------------------------------------------------
// double_dabble_hs
//
// Sequential binary-to-BCD converter (shift-and-add-3 / "double dabble") with a
// valid/ready handshake on both sides. One operand is accepted in IDLE. The
// block then runs exactly N SHIFT cycles and presents the packed BCD magnitude,
// a sign flag and a significant-digit count in DONE until the consumer takes
// it. Two's-complement operands are folded to their magnitude on accept.
//
// Ports
//   Clock     in   rising-edge clock
//   Reset     in   asynchronous, active-low reset
//   InValid   in   operand on V/Signed is valid
//   InReady   out  block is idle and will accept an operand
//   V         in   N-bit binary operand
//   Signed    in   1 = V is two's complement, 0 = V is unsigned
//   OutValid  out  result on BCD/Negative/Digits is presented
//   OutReady  in   consumer accepts the presented result
//   BCD       out  4*D-bit packed BCD magnitude, digit 0 in bits [3:0]
//   Negative  out  result is negative (never set for a zero magnitude)
//   Digits    out  number of significant decimal digits, 1..D
// -----------------------------------------------------------------------------
module double_dabble_hs #(
  parameter  int N  = 32,
  localparam int D  = (N + 2) / 3,
  localparam int DW = $clog2(D + 1)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [N-1:0]    V,
  input  logic            Signed,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [4*D-1:0]  BCD,
  output logic            Negative,
  output logic [DW-1:0]   Digits
);

  // Iteration counter only needs to reach N-1.
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [4*D-1:0]   scratch_q;     // BCD digits being built up
  logic [N-1:0]     mag_q;         // magnitude bits still to be shifted in
  logic             neg_q;         // sign of the operand in flight
  logic [CW-1:0]    cnt_q;         // SHIFT iterations already performed
  logic [4*D-1:0]   bcd_q;         // last delivered result
  logic             negative_q;
  logic [DW-1:0]    digits_q;

  // ---------------------------------------------------------------------------
  // Operand folding: a negative two's-complement operand becomes -V taken as
  // an N-bit unsigned value. For the most negative value this wraps back to
  // 2^(N-1), which is exactly the magnitude wanted.
  // ---------------------------------------------------------------------------
  logic             neg_in;
  logic [N-1:0]     mag_in;

  assign neg_in = Signed & V[N-1];
  assign mag_in = neg_in ? (~V + N'(1)) : V;

  // ---------------------------------------------------------------------------
  // One double-dabble iteration and the digit count of its result.
  // ---------------------------------------------------------------------------
  logic [4*D-1:0]   adj;
  logic [4*D-1:0]   scratch_d;
  logic [N-1:0]     mag_d;
  logic [DW-1:0]    digits_d;

  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so no
    // path leaves it unassigned and no latch is inferred.
    adj      = scratch_q;
    digits_d = DW'(1);

    // Any digit >= 5 would overflow past 9 when doubled; pre-adding 3 makes the
    // doubling carry into the next digit instead.
    for (int i = 0; i < D; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end

    // Shift {scratch, magnitude} left by one: the magnitude MSB enters digit 0.
    scratch_d = {adj[4*D-2:0], mag_q[N-1]};
    mag_d     = {mag_q[N-2:0], 1'b0};

    // Highest nonzero digit wins; an all-zero value still reports one digit.
    for (int i = 1; i < D; i++) begin
      if (scratch_d[4*i +: 4] != 4'd0) begin
        digits_d = DW'(i + 1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered handshake and result outputs.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      // NOTE: datapath registers are reset along with control, so an aborted
      // conversion leaves no stale scratch behind for the next operand.
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      scratch_q   <= '0;
      mag_q       <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      negative_q  <= 1'b0;
      digits_q    <= DW'(1);
    end else begin
      case (state_q)
        IDLE: begin
          // InReady is high exactly in IDLE, so InValid alone means accept.
          if (InValid) begin
            mag_q      <= mag_in;
            neg_q      <= neg_in;
            scratch_q  <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end

        SHIFT: begin
          scratch_q <= scratch_d;
          mag_q     <= mag_d;
          cnt_q     <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            // Last iteration: publish straight from the shifted value so the
            // result appears N edges after accept.
            bcd_q       <= scratch_d;
            negative_q  <= neg_q & (scratch_d != '0);
            digits_q    <= digits_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          if (OutReady) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign BCD      = bcd_q;
  assign Negative = negative_q;
  assign Digits   = digits_q;

endmodule
